// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: walks one input vector through NUM_NEURONS weight rows,
// issuing one dot-product job per neuron to an external PE and collecting
// each (optionally ReLU-clamped) result into a flat output vector.
//
// Handshake with the PE: pe_start is a one-cycle pulse issued in ISSUE while
// row/bias/vector are presented; the PE drops pe_done on that start edge and
// raises it (level) when pe_result is valid, holding it until the next start.
// The first WAIT cycle ignores pe_done so a stale level from the previous job
// is never mistaken for completion.
module layer_seq_ctrl #(
    parameter int VECTOR_LENGTH = 64,
    parameter int W             = 8,
    parameter int ACC_WIDTH     = W + 7,
    parameter int NUM_NEURONS   = 16,
    parameter int RELU          = 1,
    parameter int TIMEOUT       = 4 * VECTOR_LENGTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [W*VECTOR_LENGTH-1:0]           in_vector_flat,
    input  logic [W*VECTOR_LENGTH*NUM_NEURONS-1:0] weight_mat_flat,
    input  logic [W*NUM_NEURONS-1:0]             bias_flat,
    input  logic [ACC_WIDTH-1:0]                 pe_result,
    input  logic                                 pe_done,
    output logic                                 pe_start,
    output logic [W*VECTOR_LENGTH-1:0]           pe_in_vector_flat,
    output logic [W*VECTOR_LENGTH-1:0]           pe_weight_row_flat,
    output logic [W-1:0]                         pe_bias,
    output logic [ACC_WIDTH*NUM_NEURONS-1:0]     out_vector_flat,
    output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] neuron_idx,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int ROW_W = W * VECTOR_LENGTH;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    // State is kept in a named enum register so checkers can bind to it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                         state, state_next;
    logic [IDX_W-1:0]               idx_q, idx_next;
    logic [CNT_W-1:0]               cnt_q, cnt_next;
    logic                           err_q, err_next;
    logic [ACC_WIDTH*NUM_NEURONS-1:0] out_q, out_next;
    logic [ROW_W-1:0]               vec_q, vec_next;
    logic [ACC_WIDTH-1:0]           slot_val;

    // ReLU looks only at the sign bit; the value is otherwise stored untouched.
    always_comb begin
        slot_val = pe_result;
        if (RELU != 0 && pe_result[ACC_WIDTH-1]) slot_val = '0;
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_next = state;
        idx_next   = idx_q;
        cnt_next   = cnt_q;
        err_next   = err_q;
        out_next   = out_q;
        vec_next   = vec_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    vec_next   = in_vector_flat;
                    out_next   = '0;
                    idx_next   = '0;
                    err_next   = 1'b0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_q != '0 && pe_done) begin
                    out_next[idx_q*ACC_WIDTH +: ACC_WIDTH] = slot_val;
                    if (idx_q == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_q + 1'b1;
                        state_next = ISSUE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // PE never answered: flag it and leave this slot at 0.
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            out_q <= '0;
            vec_q <= '0;
        end else begin
            state <= state_next;
            idx_q <= idx_next;
            cnt_q <= cnt_next;
            err_q <= err_next;
            out_q <= out_next;
            vec_q <= vec_next;
        end
    end

    // Outputs decode directly from registered state so they drop the cycle after reset.
    always_comb begin
        pe_start           = (state == ISSUE);
        busy               = (state == ISSUE) || (state == WAIT);
        done               = (state == DONE);
        err                = err_q;
        neuron_idx         = idx_q;
        out_vector_flat    = out_q;
        pe_in_vector_flat  = vec_q;
        pe_weight_row_flat = weight_mat_flat[idx_q*ROW_W +: ROW_W];
        pe_bias            = bias_flat[idx_q*W +: W];
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: two instances (RELU=0 and RELU=1) share stimulus,
// each paired with a fixed-latency PE model.
module tb_layer_seq_ctrl;

    localparam int VL  = 4;
    localparam int NN  = 2;
    localparam int W   = 8;
    localparam int ACC = W + 7;
    localparam int TO  = 4 * VL;
    localparam int PE_LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [W*VL-1:0]   in_vec = '0;
    logic [W*VL*NN-1:0] wmat = '0;
    logic [W*NN-1:0]   bias = '0;
    logic              pe_hang = 1'b0;

    logic [ACC-1:0]    pe_result0, pe_result1;
    logic              pe_done0, pe_done1, pe_start0, pe_start1;
    logic [W*VL-1:0]   pe_vec0, pe_vec1, pe_row0, pe_row1;
    logic [W-1:0]      pe_bias0, pe_bias1;
    logic [ACC*NN-1:0] out0, out1;
    logic [0:0]        idx0, idx1;
    logic              busy0, busy1, done0, done1, err0, err1;
    int                lat0, lat1;
    int                pulses0;

    int checks = 0;
    int errors = 0;

    layer_seq_ctrl #(.VECTOR_LENGTH(VL), .W(W), .NUM_NEURONS(NN), .RELU(0)) u0 (
        .clk(clk), .reset(reset), .start(start), .in_vector_flat(in_vec),
        .weight_mat_flat(wmat), .bias_flat(bias), .pe_result(pe_result0),
        .pe_done(pe_done0), .pe_start(pe_start0), .pe_in_vector_flat(pe_vec0),
        .pe_weight_row_flat(pe_row0), .pe_bias(pe_bias0), .out_vector_flat(out0),
        .neuron_idx(idx0), .busy(busy0), .done(done0), .err(err0)
    );

    layer_seq_ctrl #(.VECTOR_LENGTH(VL), .W(W), .NUM_NEURONS(NN), .RELU(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .in_vector_flat(in_vec),
        .weight_mat_flat(wmat), .bias_flat(bias), .pe_result(pe_result1),
        .pe_done(pe_done1), .pe_start(pe_start1), .pe_in_vector_flat(pe_vec1),
        .pe_weight_row_flat(pe_row1), .pe_bias(pe_bias1), .out_vector_flat(out1),
        .neuron_idx(idx1), .busy(busy1), .done(done1), .err(err1)
    );

    // ---------------- PE models ----------------
    function automatic logic [ACC-1:0] dot(input logic [W*VL-1:0] v,
                                           input logic [W*VL-1:0] r,
                                           input logic [W-1:0] b);
        int acc;
        acc = int'($signed(b));
        for (int i = 0; i < VL; i++)
            acc += int'($signed(v[i*W +: W])) * int'($signed(r[i*W +: W]));
        return ACC'(acc);
    endfunction

    // Result is taken from the PE-facing ports at completion time, so any
    // instability of vector/row/bias during the job shows up in the output.
    always @(posedge clk) begin
        if (reset) begin
            pe_done0 <= 1'b0; lat0 <= 0; pe_result0 <= '0;
        end else if (pe_start0) begin
            pe_done0 <= 1'b0; lat0 <= PE_LAT;
        end else if (lat0 != 0) begin
            lat0 <= lat0 - 1;
            if (lat0 == 1 && !pe_hang) begin
                pe_done0   <= 1'b1;
                pe_result0 <= dot(pe_vec0, pe_row0, pe_bias0);
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            pe_done1 <= 1'b0; lat1 <= 0; pe_result1 <= '0;
        end else if (pe_start1) begin
            pe_done1 <= 1'b0; lat1 <= PE_LAT;
        end else if (lat1 != 0) begin
            lat1 <= lat1 - 1;
            if (lat1 == 1 && !pe_hang) begin
                pe_done1   <= 1'b1;
                pe_result1 <= dot(pe_vec1, pe_row1, pe_bias1);
            end
        end
    end

    always @(posedge clk) begin
        if (pe_start0) pulses0 <= pulses0 + 1;
    end
    initial pulses0 = 0;

    // ---------------- stimulus helpers ----------------
    function automatic logic [W*VL-1:0] vec4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [ACC*NN-1:0] res2(input int n0, input int n1);
        return {ACC'(n1), ACC'(n0)};
    endfunction

    task automatic load(input logic [W*VL-1:0] v, input logic [W*VL-1:0] r0,
                        input logic [W*VL-1:0] r1, input int b0, input int b1);
        in_vec = v;
        wmat   = {r1, r0};
        bias   = {W'(b1), W'(b0)};
    endtask

    // Pulses start for one cycle; returns at the negedge after the ISSUE entry edge.
    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err0); end
        checks++; if (pe_start0 !== 1'b0) begin errors++; $display("FAIL reset_pe_start got %b exp 0", pe_start0); end
        checks++; if (idx0 !== 1'b0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx0); end
        checks++; if (out0 !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out0); end
        checks++; if (pe_vec0 !== '0) begin errors++; $display("FAIL reset_pe_vec got %h exp 0", pe_vec0); end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        int p0;
        load(vec4(1, 2, 3, 4), vec4(1, 1, 1, 1), vec4(-1, 0, 0, 0), 0, 5);
        p0 = pulses0;
        pulse_start();
        checks++; if (busy0 !== 1'b1 || pe_start0 !== 1'b1) begin errors++; $display("FAIL basic_issue busy %b pe_start %b exp 1 1", busy0, pe_start0); end
        @(negedge clk);
        checks++; if (pe_start0 !== 1'b0) begin errors++; $display("FAIL basic_wait_pe_start got %b exp 0", pe_start0); end
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout done got 0 exp 1"); end
        checks++; if (out0 !== res2(10, 4)) begin errors++; $display("FAIL basic_out got %h exp %h", out0, res2(10, 4)); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", err0); end
        checks++; if (pulses0 - p0 !== 2) begin errors++; $display("FAIL basic_pulses got %0d exp 2", pulses0 - p0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy0); end
        repeat (3) @(negedge clk);
        checks++; if (done0 !== 1'b1 || out0 !== res2(10, 4)) begin errors++; $display("FAIL basic_hold done %b out %h exp 1 %h", done0, out0, res2(10, 4)); end
    endtask

    task automatic test_relu;
        bit ok;
        load(vec4(1, 2, 3, 4), vec4(-1, -1, -1, -1), vec4(1, 0, 0, 0), 0, 0);
        pulse_start();
        wait_done(100, ok);
        checks++; if (!ok || done1 !== 1'b1) begin errors++; $display("FAIL relu_done got %b exp 1", done1); end
        checks++; if (out1 !== res2(0, 1)) begin errors++; $display("FAIL relu_out got %h exp %h", out1, res2(0, 1)); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL relu_err got %b exp 0", err1); end
        checks++; if (out0 !== res2(-10, 1)) begin errors++; $display("FAIL norelu_out got %h exp %h", out0, res2(-10, 1)); end
    endtask

    task automatic test_start_ignored;
        bit ok;
        int p0;
        load(vec4(1, 2, 3, 4), vec4(1, 1, 1, 1), vec4(-1, 0, 0, 0), 0, 5);
        p0 = pulses0;
        pulse_start();
        @(negedge clk);
        in_vec = vec4(5, 5, 5, 5);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout done got 0 exp 1"); end
        checks++; if (out0 !== res2(10, 4)) begin errors++; $display("FAIL ignore_out got %h exp %h", out0, res2(10, 4)); end
        checks++; if (pulses0 - p0 !== 2) begin errors++; $display("FAIL ignore_pulses got %0d exp 2", pulses0 - p0); end
        checks++; if (pe_vec0 !== vec4(1, 2, 3, 4)) begin errors++; $display("FAIL ignore_latched got %h exp %h", pe_vec0, vec4(1, 2, 3, 4)); end
        in_vec = vec4(1, 2, 3, 4);
    endtask

    task automatic test_timeout;
        pe_hang = 1'b1;
        load(vec4(1, 2, 3, 4), vec4(1, 1, 1, 1), vec4(-1, 0, 0, 0), 0, 5);
        pulse_start();
        checks++; if (pe_start0 !== 1'b1) begin errors++; $display("FAIL to_issue pe_start got %b exp 1", pe_start0); end
        repeat (TO) @(negedge clk);
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL to_early done got %b exp 0", done0); end
        @(negedge clk);
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL to_done got %b exp 1", done0); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err0); end
        checks++; if (out0[ACC-1:0] !== '0) begin errors++; $display("FAIL to_slot0 got %h exp 0", out0[ACC-1:0]); end
        checks++; if (idx0 !== 1'b0) begin errors++; $display("FAIL to_idx got %0d exp 0", idx0); end
        pe_hang = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit found;
        int p0;
        load(vec4(1, 2, 3, 4), vec4(1, 1, 1, 1), vec4(-1, 0, 0, 0), 0, 5);
        pulse_start();
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rm_err_cleared got %b exp 0", err0); end
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (idx0 == 1'b1 && busy0 && !pe_start0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rm_reach_n1 got 0 exp 1"); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || pe_start0 !== 1'b0) begin
            errors++; $display("FAIL rm_flags busy %b done %b err %b pe_start %b exp 0 0 0 0", busy0, done0, err0, pe_start0);
        end
        checks++; if (idx0 !== 1'b0) begin errors++; $display("FAIL rm_idx got %0d exp 0", idx0); end
        checks++; if (out0 !== '0) begin errors++; $display("FAIL rm_out got %h exp 0", out0); end
        checks++; if (pe_vec0 !== '0) begin errors++; $display("FAIL rm_vec got %h exp 0", pe_vec0); end
        reset = 1'b0;
        p0 = pulses0;
        pulse_start();
        checks++; if (idx0 !== 1'b0) begin errors++; $display("FAIL rm_restart_idx got %0d exp 0", idx0); end
        wait_done(100, ok);
        checks++; if (!ok || out0 !== res2(10, 4)) begin errors++; $display("FAIL rm_out_after got %h exp %h", out0, res2(10, 4)); end
        checks++; if (pulses0 - p0 !== 2 || err0 !== 1'b0) begin errors++; $display("FAIL rm_pulses got %0d err %b exp 2 0", pulses0 - p0, err0); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        load(vec4(1, 2, 3, 4), vec4(2, 0, 0, 0), vec4(0, 0, 0, -1), 1, -1);
        pulse_start();
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL b2b_done got %b exp 0", done0); end
        checks++; if (out0 !== '0) begin errors++; $display("FAIL b2b_cleared got %h exp 0", out0); end
        checks++; if (busy0 !== 1'b1 || idx0 !== 1'b0) begin errors++; $display("FAIL b2b_issue busy %b idx %0d exp 1 0", busy0, idx0); end
        wait_done(100, ok);
        checks++; if (!ok || out0 !== res2(3, -5)) begin errors++; $display("FAIL b2b_out got %h exp %h", out0, res2(3, -5)); end
        checks++; if (out1 !== res2(3, 0)) begin errors++; $display("FAIL b2b_relu_out got %h exp %h", out1, res2(3, 0)); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_start_ignored();
        test_timeout();
        test_reset_mid();
        test_basic();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 Parameters SHALL be: VECTOR_LENGTH 64, elements per input vector; W 8, element/weight/bias width; ACC_WIDTH W+7, PE result width; NUM_NEURONS 16, weight rows per layer; RELU 1, clamp negative results to 0 when 1; TIMEOUT 4*VECTOR_LENGTH, max WAIT cycles per neuron.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle layer start request
- in_vector_flat  in  W*VECTOR_LENGTH  signed layer input, element i at [i*W +: W]
- weight_mat_flat  in  W*VECTOR_LENGTH*NUM_NEURONS  row n at [n*W*VECTOR_LENGTH +: W*VECTOR_LENGTH]
- bias_flat  in  W*NUM_NEURONS  bias n at [n*W +: W]
- pe_result  in  ACC_WIDTH  signed PE dot-product result
- pe_done  in  1  PE completion level; high until next pe_start
- pe_start  out  1  one-cycle PE start pulse
- pe_in_vector_flat  out  W*VECTOR_LENGTH  latched input vector to PE
- pe_weight_row_flat  out  W*VECTOR_LENGTH  current weight row to PE
- pe_bias  out  W  current bias to PE
- out_vector_flat  out  ACC_WIDTH*NUM_NEURONS  signed results, neuron n at [n*ACC_WIDTH +: ACC_WIDTH]
- neuron_idx  out  clog2(NUM_NEURONS) (min 1)  neuron in progress
- busy  out  1  high in ISSUE or WAIT
- done  out  1  level, high in DONE
- err  out  1  timeout flag, valid with done

Function
REQ-003 FSM SHALL have states IDLE, ISSUE, WAIT, DONE; reset enters IDLE.
REQ-004 IDLE/DONE + start: latch in_vector_flat into pe_in_vector_flat, clear out_vector_flat, neuron_idx=0, err=0, done=0, go ISSUE; start ignored in ISSUE/WAIT.
REQ-005 ISSUE SHALL last exactly one cycle with pe_start=1, clear the timeout counter, then go WAIT; pe_start SHALL be 0 in every other state.
REQ-006 pe_weight_row_flat and pe_bias SHALL be row/bias neuron_idx and SHALL be stable from ISSUE through the cycle pe_done is sampled.
REQ-007 WAIT SHALL ignore pe_done in its first cycle (PE done flag clears on the start edge), then sample pe_done each cycle.
REQ-008 On pe_done=1 in WAIT: write slot neuron_idx with pe_result, or 0 if RELU=1 and pe_result<0; if neuron_idx==NUM_NEURONS-1 go DONE, else increment neuron_idx and go ISSUE.
REQ-009 Per-neuron period SHALL be 1 (ISSUE) + number of WAIT cycles up to and including the pe_done sample; no idle gaps between neurons.
REQ-010 Timeout counter SHALL increment each WAIT cycle; at TIMEOUT cycles without pe_done: err=1, slot left 0, go DONE.
REQ-011 DONE SHALL hold done=1, out_vector_flat, err, neuron_idx until start or reset.
REQ-012 pe_in_vector_flat SHALL not change during ISSUE/WAIT even if in_vector_flat changes.
REQ-013 Results SHALL be stored bit-exact (no truncation); ReLU compares the sign bit only.

Reset
REQ-014 reset SHALL dominate start and any state, including mid-WAIT: next cycle state IDLE, pe_start 0, busy 0, done 0, err 0, neuron_idx 0, out_vector_flat 0, pe_in_vector_flat 0.
REQ-015 After reset mid-layer, the first start SHALL begin at neuron 0 with no residue from the aborted layer.

Verification
REQ-016 Bench SHALL pair the block with a PE model of fixed latency and cover:
- VECTOR_LENGTH=4, NUM_NEURONS=2, RELU=0, in=[1,2,3,4], rows [1,1,1,1],[-1,0,0,0], bias [0,5] -> out=[10,4], done=1, err=0, exactly 2 pe_start pulses.
- Same with RELU=1, rows [-1,-1,-1,-1],[1,0,0,0], bias [0,0] -> out=[0,1].
- start re-pulsed during WAIT, in_vector_flat changed mid-layer -> ignored, results use latched vector, 2 pulses total.
- PE model never raises pe_done -> err=1, done=1 after 1+TIMEOUT cycles, slot 0 = 0.
- reset during WAIT of neuron 1 -> all outputs 0 next cycle; new start yields correct full result.
- Back-to-back: start in DONE -> done=0 next cycle, out_vector_flat cleared, second layer correct.
